// File: rtl/dflipflop_seq_pkg.sv
// Shared types and helpers for the flip-flop chain load sequencer.
// State encodings are fixed here so the enum and any external decode agree.
package dflipflop_seq_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
  localparam logic [1:0] ST_SETTLE_ENC = 2'd2;
  localparam logic [1:0] ST_UPDATE_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE_ENC,
    SHIFT  = ST_SHIFT_ENC,
    SETTLE = ST_SETTLE_ENC,
    UPDATE = ST_UPDATE_ENC
  } seq_state_t;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dflipflop_seq_shifter.sv
// Load/shift register feeding the chain; the head bit is a flop output.
// The word is reordered at load so shifting is always toward the MSB end.
module dflipflop_seq_shifter
  import dflipflop_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] data,
  output logic             cur_bit
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] ordered;

  // Bit-reverse LSB-first words so the next bit out is always sr_q[WIDTH-1].
  always_comb begin
    ordered = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ordered[i] = msb_first ? data[i] : data[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= ordered;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign cur_bit = sr_q[WIDTH-1];

endmodule

// File: rtl/dflipflop_chain_load_sequencer.sv
// Sequences a serial D flip-flop chain: accept word, shift WIDTH bits,
// settle, pulse update, then report done (or aborted).
module dflipflop_chain_load_sequencer
  import dflipflop_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SETTLE_LEN = 1,
  parameter int unsigned UPDATE_LEN = 1
) (
  input  logic             input_clock_clk,
  input  logic             input_reset_rst_n,
  input  logic             input_load_valid,
  output logic             output_load_ready,
  input  logic [WIDTH-1:0] input_load_data,
  input  logic             input_msb_first,
  input  logic             input_abort,
  output logic             output_chain_d,
  output logic             output_chain_shift_en,
  output logic             output_chain_update,
  output logic             output_busy,
  output logic             output_done,
  output logic             output_aborted
);

  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam int unsigned TMAX = (SETTLE_LEN > UPDATE_LEN) ? SETTLE_LEN : UPDATE_LEN;
  localparam int unsigned TW   = cnt_width(TMAX);

  localparam logic [CW-1:0] BIT_LAST    = CW'(WIDTH - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
  localparam logic [TW-1:0] UPDATE_LAST = TW'(UPDATE_LEN - 1);

  seq_state_t    state_q, state_n;
  logic [CW-1:0] bit_cnt_q, bit_cnt_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic          load_word, shift_word;
  logic          done_n, aborted_n;
  logic          shift_en_q, update_q, busy_q, done_q, aborted_q;

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    tmr_n      = tmr_q;
    load_word  = 1'b0;
    shift_word = 1'b0;
    done_n     = 1'b0;
    aborted_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_load_valid) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
          load_word = 1'b1;
        end
      end
      SHIFT: begin
        if (input_abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (bit_cnt_q == BIT_LAST) begin
          // No shift on the final bit so chain_d holds it through settle.
          tmr_n = '0;
          if (SETTLE_LEN > 0) state_n = SETTLE;
          else                state_n = UPDATE;
        end else begin
          bit_cnt_n  = bit_cnt_q + CW'(1);
          shift_word = 1'b1;
        end
      end
      SETTLE: begin
        if (input_abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (tmr_q == SETTLE_LAST) begin
          tmr_n   = '0;
          state_n = UPDATE;
        end else begin
          tmr_n = tmr_q + TW'(1);
        end
      end
      UPDATE: begin
        if (tmr_q == UPDATE_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          tmr_n = tmr_q + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge input_clock_clk or negedge input_reset_rst_n) begin
    if (!input_reset_rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tmr_q      <= '0;
      shift_en_q <= 1'b0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      tmr_q      <= tmr_n;
      shift_en_q <= (state_n == SHIFT);
      update_q   <= (state_n == UPDATE);
      busy_q     <= (state_n != IDLE);
      done_q     <= done_n;
      aborted_q  <= aborted_n;
    end
  end

  dflipflop_seq_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk      (input_clock_clk),
    .rst_n    (input_reset_rst_n),
    .load     (load_word),
    .shift    (shift_word),
    .msb_first(input_msb_first),
    .data     (input_load_data),
    .cur_bit  (output_chain_d)
  );

  assign output_load_ready     = (state_q == IDLE);
  assign output_chain_shift_en = shift_en_q;
  assign output_chain_update   = update_q;
  assign output_busy           = busy_q;
  assign output_done           = done_q;
  assign output_aborted        = aborted_q;

endmodule
